// File: rtl/array_lookup_pkg.sv
// Shared types for the array lookup arbiter: requester index width and the
// {valid, requester} tag that travels alongside each lookup.
package array_lookup_pkg;

  localparam int unsigned MAX_REQ = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tags are sized for the largest supported requester count.
  localparam int unsigned IDX_WIDTH = idx_width(MAX_REQ);

  typedef logic [IDX_WIDTH-1:0] req_idx_t;

  typedef struct packed {
    logic     valid;
    req_idx_t idx;
  } tag_t;

endpackage

// File: rtl/array_lookup_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after i_ptr wins.
module rr_arbiter
  import array_lookup_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt_c,
  output logic [IW-1:0] o_gnt_idx_c
);

  int unsigned w_pos;
  logic        w_found;

  // Walk ptr, ptr+1, ... modulo N and keep only the first hit.
  always_comb begin
    o_gnt_c     = '0;
    o_gnt_idx_c = '0;
    w_found     = 1'b0;
    w_pos       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_pos = 32'(i_ptr) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      if (!w_found && i_req[IW'(w_pos)]) begin
        w_found              = 1'b1;
        o_gnt_c[IW'(w_pos)]  = 1'b1;
        o_gnt_idx_c          = IW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/array_lookup_arb.sv
// Shares one synchronous-read lookup table among N_REQ requesters with
// round-robin grants and in-order, one-hot routed responses.
module array_lookup_arb
  import array_lookup_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned ADDR_WIDTH     = 2,
  parameter int unsigned DATA_WIDTH     = 25,
  parameter int unsigned LOOKUP_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] i_req_addr,
  output logic [N_REQ-1:0]            o_req_ready_c,
  output logic [N_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]       o_rsp_data_c,
  output logic                        o_arr_en,
  output logic [ADDR_WIDTH-1:0]       o_arr_addr,
  input  logic [DATA_WIDTH-1:0]       i_arr_data,
  output logic                        o_busy
);

  localparam int unsigned SEL_W = idx_width(N_REQ);

  logic [SEL_W-1:0]      r_ptr;
  tag_t                  r_tag [LOOKUP_LATENCY];
  logic                  r_arr_en;
  logic [ADDR_WIDTH-1:0] r_arr_addr;
  logic [N_REQ-1:0]      r_rsp_valid;
  logic                  r_busy;

  logic [N_REQ-1:0]      w_gnt;
  logic [SEL_W-1:0]      w_gnt_idx;
  logic                  w_hs;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  tag_t                  w_tag_nxt [LOOKUP_LATENCY];
  logic [N_REQ-1:0]      w_rsp_nxt;
  logic                  w_busy_nxt;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (SEL_W)
  ) u_rr_arbiter (
    .i_req       (i_req_valid),
    .i_ptr       (r_ptr),
    .o_gnt_c     (w_gnt),
    .o_gnt_idx_c (w_gnt_idx)
  );

  assign o_req_ready_c = rst ? '0 : w_gnt;
  assign w_hs          = |o_req_ready_c;

  always_comb begin
    w_sel_addr = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (o_req_ready_c[i]) w_sel_addr = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // The registered one-hot r_rsp_valid acts as the final tag stage.
  always_comb begin
    w_tag_nxt[0] = '{valid: w_hs, idx: req_idx_t'(w_gnt_idx)};
    for (int unsigned k = 1; k < LOOKUP_LATENCY; k++) begin
      w_tag_nxt[k] = r_tag[k-1];
    end
    w_rsp_nxt = '0;
    if (r_tag[LOOKUP_LATENCY-1].valid) begin
      w_rsp_nxt[SEL_W'(r_tag[LOOKUP_LATENCY-1].idx)] = 1'b1;
    end
    w_busy_nxt = |w_rsp_nxt;
    for (int unsigned k = 0; k < LOOKUP_LATENCY; k++) begin
      w_busy_nxt = w_busy_nxt | w_tag_nxt[k].valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_arr_en    <= 1'b0;
      r_arr_addr  <= '0;
      r_rsp_valid <= '0;
      r_busy      <= 1'b0;
      for (int unsigned k = 0; k < LOOKUP_LATENCY; k++) r_tag[k] <= '0;
    end else begin
      r_arr_en    <= w_hs;
      r_rsp_valid <= w_rsp_nxt;
      r_busy      <= w_busy_nxt;
      for (int unsigned k = 0; k < LOOKUP_LATENCY; k++) r_tag[k] <= w_tag_nxt[k];
      if (w_hs) begin
        r_arr_addr <= w_sel_addr;
        r_ptr      <= (32'(w_gnt_idx) == N_REQ - 1) ? '0 : SEL_W'(w_gnt_idx + 1'b1);
      end
    end
  end

  // A lookup issued just before reset must not surface while reset is held.
  assign o_arr_en     = r_arr_en & ~rst;
  assign o_arr_addr   = r_arr_addr;
  assign o_rsp_valid  = rst ? '0 : r_rsp_valid;
  assign o_busy       = r_busy & ~rst;
  assign o_rsp_data_c = i_arr_data;

endmodule

// File: tb/tb_array_lookup_arb.sv
// Bench for array_lookup_arb: a 4-requester and a 3-requester instance checked
// each cycle against a time-indexed handshake history model.
module tb_array_lookup_arb;

  localparam int LAT  = 1;
  localparam int NCYC = 1024;

  logic clk;
  logic rst;

  logic [3:0]  a_valid, a_ready, a_rsp;
  logic [7:0]  a_addr;
  logic [24:0] a_data, a_arr_q;
  logic        a_en, a_busy;
  logic [1:0]  a_arr_addr;

  logic [2:0]  b_valid, b_ready, b_rsp;
  logic [11:0] b_addr;
  logic [24:0] b_data, b_arr_q;
  logic        b_en, b_busy;
  logic [3:0]  b_arr_addr;

  int n_tests, n_fail, cyc;

  bit         hs_v [2][NCYC];
  int         hs_i [2][NCYC];
  logic [3:0] hs_a [2][NCYC];
  int         m_ptr  [2];
  logic [3:0] m_addr [2];

  array_lookup_arb #(.N_REQ(4), .ADDR_WIDTH(2), .DATA_WIDTH(25), .LOOKUP_LATENCY(1)) u_dut_a (
    .clk(clk), .rst(rst), .i_req_valid(a_valid), .i_req_addr(a_addr),
    .o_req_ready_c(a_ready), .o_rsp_valid(a_rsp), .o_rsp_data_c(a_data),
    .o_arr_en(a_en), .o_arr_addr(a_arr_addr), .i_arr_data(a_arr_q), .o_busy(a_busy));

  array_lookup_arb #(.N_REQ(3), .ADDR_WIDTH(4), .DATA_WIDTH(25), .LOOKUP_LATENCY(1)) u_dut_b (
    .clk(clk), .rst(rst), .i_req_valid(b_valid), .i_req_addr(b_addr),
    .o_req_ready_c(b_ready), .o_rsp_valid(b_rsp), .o_rsp_data_c(b_data),
    .o_arr_en(b_en), .o_arr_addr(b_arr_addr), .i_arr_data(b_arr_q), .o_busy(b_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table entry a holds (a+1).0 with 16 fractional bits.
  function automatic logic [24:0] tbl(input int a);
    return 25'((a + 1) << 16);
  endfunction

  always @(posedge clk) begin
    if (a_en) a_arr_q <= tbl(int'(a_arr_addr));
    if (b_en) b_arr_q <= tbl(int'(b_arr_addr));
  end

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] cyc=%0d observed=0x%0h expected=0x%0h", tag, inst, cyc, obs, exp);
    end
  endtask

  task automatic evaluate(input int inst);
    int n, g, p;
    logic [3:0] vld, ob_rdy, ob_rsp, ob_addr, exp_rdy, exp_rsp;
    logic [3:0] adr [4];
    logic [24:0] ob_dat;
    logic ob_en, ob_busy, exp_en, exp_busy;
    if (inst == 0) begin
      n = 4; vld = a_valid; ob_rdy = a_ready; ob_rsp = a_rsp; ob_dat = a_data;
      ob_en = a_en; ob_addr = 4'(a_arr_addr); ob_busy = a_busy;
      for (int i = 0; i < 4; i++) adr[i] = 4'(a_addr[i*2 +: 2]);
    end else begin
      n = 3; vld = {1'b0, b_valid}; ob_rdy = {1'b0, b_ready}; ob_rsp = {1'b0, b_rsp};
      ob_dat = b_data; ob_en = b_en; ob_addr = b_arr_addr; ob_busy = b_busy;
      for (int i = 0; i < 3; i++) adr[i] = b_addr[i*4 +: 4];
      adr[3] = '0;
    end
    g = -1;
    if (!rst) begin
      for (int k = 0; k < n; k++) begin
        p = (m_ptr[inst] + k) % n;
        if (g < 0 && vld[p]) g = p;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", inst, 32'(ob_rdy), 32'(exp_rdy));
    exp_en = !rst && hs_v[inst][cyc-1];
    if (hs_v[inst][cyc-1]) m_addr[inst] = hs_a[inst][cyc-1];
    chk("arr_en", inst, 32'(ob_en), 32'(exp_en));
    chk("arr_addr", inst, 32'(ob_addr), 32'(m_addr[inst]));
    exp_rsp = '0;
    if (!rst && hs_v[inst][cyc-1-LAT]) exp_rsp[hs_i[inst][cyc-1-LAT]] = 1'b1;
    chk("rsp_valid", inst, 32'(ob_rsp), 32'(exp_rsp));
    if (exp_rsp != '0) chk("rsp_data", inst, 32'(ob_dat), 32'(tbl(int'(hs_a[inst][cyc-1-LAT]))));
    exp_busy = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) exp_busy = exp_busy | hs_v[inst][cyc-k];
    exp_busy = exp_busy & !rst;
    chk("busy", inst, 32'(ob_busy), 32'(exp_busy));
    hs_v[inst][cyc] = (g >= 0);
    if (g >= 0) begin
      hs_i[inst][cyc] = g;
      hs_a[inst][cyc] = adr[g];
      m_ptr[inst]     = (g + 1) % n;
    end
    if (rst) begin
      m_ptr[inst]  = 0;
      m_addr[inst] = '0;
      for (int k = 1; k <= LAT; k++) hs_v[inst][cyc-k] = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    evaluate(0);
    evaluate(1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic bit accepted(input int inst, input int i);
    return hs_v[inst][cyc-1] && hs_i[inst][cyc-1] == i;
  endfunction

  initial begin
    n_tests = 0; n_fail = 0; cyc = 2;
    m_ptr[0] = 0; m_ptr[1] = 0; m_addr[0] = '0; m_addr[1] = '0;
    rst = 1'b1; a_valid = '0; a_addr = '0; b_valid = '0; b_addr = '0;
    @(posedge clk); #1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single requester: grant, issue, response.
    a_valid = 4'b0001; a_addr[1:0] = 2'd2;
    #1 chk("t1_ready", 0, 32'(a_ready), 32'h1);
    tick();
    a_valid = '0;
    #1 chk("t1_en", 0, 32'(a_en), 32'h1);
    chk("t1_addr", 0, 32'(a_arr_addr), 32'h2);
    tick();
    #1 chk("t1_rsp", 0, 32'(a_rsp), 32'h1);
    chk("t1_data", 0, 32'(a_data), 32'(tbl(2)));
    chk("t1_busy", 0, 32'(a_busy), 32'h1);
    repeat (2) tick();

    // All four requesters continuously.
    a_valid = 4'b1111; a_addr = {2'd3, 2'd2, 2'd1, 2'd0};
    repeat (8) tick();
    a_valid = '0;
    repeat (3) tick();

    // Move ptr to 2, then only requesters 1 and 3 compete.
    a_valid = 4'b0010;
    tick();
    a_valid = 4'b1010;
    repeat (3) tick();
    a_valid = '0;
    repeat (2) tick();

    // Requester 2 streaming back-to-back.
    a_valid = 4'b0100; a_addr[5:4] = 2'd1;
    repeat (5) tick();
    a_valid = '0;
    repeat (3) tick();

    // Reset right after a handshake drops the lookup.
    a_valid = 4'b0001; a_addr[1:0] = 2'd0;
    tick();
    a_valid = '0; rst = 1'b1;
    #1 chk("t5_en", 0, 32'(a_en), 32'h0);
    chk("t5_busy", 0, 32'(a_busy), 32'h0);
    chk("t5_rsp", 0, 32'(a_rsp), 32'h0);
    tick();
    rst = 1'b0; a_valid = 4'b1111;
    #1 chk("t5_first", 0, 32'(a_ready), 32'h1);
    repeat (3) tick();
    a_valid = '0;
    repeat (3) tick();

    // Three-requester instance: pointer wrap from 2 to 0.
    b_valid = 3'b010;
    tick();
    b_valid = 3'b101; b_addr[3:0] = 4'd9; b_addr[11:8] = 4'd15;
    #1 chk("t6_ready2", 1, 32'(b_ready), 32'h4);
    tick();
    b_valid = 3'b001;
    #1 chk("t6_ready0", 1, 32'(b_ready), 32'h1);
    tick();
    b_valid = '0;
    #1 chk("t6_rsp2", 1, 32'(b_rsp), 32'h4);
    chk("t6_data2", 1, 32'(b_data), 32'(tbl(15)));
    tick();
    #1 chk("t6_rsp0", 1, 32'(b_rsp), 32'h1);
    chk("t6_data0", 1, 32'(b_data), 32'(tbl(9)));
    repeat (3) tick();

    // Randomized traffic with occasional resets; addresses only move when idle or accepted.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (!a_valid[i] || accepted(0, i)) begin
          a_valid[i] = ($urandom_range(0, 2) != 0);
          a_addr[i*2 +: 2] = 2'($urandom);
        end else if ($urandom_range(0, 9) == 0) a_valid[i] = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        if (!b_valid[i] || accepted(1, i)) begin
          b_valid[i] = ($urandom_range(0, 2) != 0);
          b_addr[i*4 +: 4] = 4'($urandom);
        end else if ($urandom_range(0, 9) == 0) b_valid[i] = 1'b0;
      end
      rst = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 1'b0; a_valid = '0; b_valid = '0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
